// File: rtl/clkrst_seq_pkg.sv
// clkrst_seq_pkg: shared types and defaults for the reset/strobe sequencer.
//   seq_state_t      sequencer FSM states
//   CLKRST_DLY_W     default delay counter width
//   CLKRST_RST_DLY   default per-stage release delays (cycles)
//   CLKRST_STRB_DIV  default per-channel strobe periods (cycles)
package clkrst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    SEQ  = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

  localparam int CLKRST_DLY_W  = 27;
  localparam int CLKRST_NRST   = 3;
  localparam int CLKRST_NSTRB  = 2;
  localparam int CLKRST_RST_DLY  [CLKRST_NRST]  = '{16, 1_000_000, 100};
  localparam int CLKRST_STRB_DIV [CLKRST_NSTRB] = '{250, 100_000_000};

  // True when v is a legal counter load: nonzero and representable in w bits.
  function automatic bit dly_ok(input int v, input int w);
    return (v >= 1) && (longint'(v) <= ((longint'(1) << w) - 1));
  endfunction

endpackage

// File: rtl/clkrst_seq_strobe_div.sv
// strobe_div: free-running single-cycle strobe every DIV cycles.
//   clk      system clock
//   reset_n  async active-low reset; clears the phase counter
//   strobe   registered, high for one cycle every DIV cycles (always high if DIV=1)
module strobe_div #(
  parameter int DIV   = 1,
  parameter int DLY_W = 27
) (
  input  logic clk,
  input  logic reset_n,
  output logic strobe
);

  localparam logic [DLY_W-1:0] TOP = DLY_W'(DIV - 1);

  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic             strb_q, strb_d;

  // Strobe is registered from the terminal count, so it appears on the edge
  // after the counter reaches DIV-1: first strobe on edge DIV after reset.
  always_comb begin
    cnt_d  = (cnt_q == TOP) ? '0 : cnt_q + DLY_W'(1);
    strb_d = (cnt_q == TOP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      strb_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      strb_q <= strb_d;
    end
  end

  assign strobe = strb_q;

endmodule

// File: rtl/clkrst_seq.sv
// clkrst_seq: ordered reset release sequencer plus free-running strobes.
//   clk         system clock (post-PLL)
//   reset_n     async active-low reset, already synchronised to clk
//   resync_req  single-cycle pulse: assert all resets, hold, then re-sequence
//   rst_out     per-stage reset, active-1; bit 0 releases first
//   seq_done    high once every stage is released
//   strobe      per-channel single-cycle strobe, independent of resync_req
module clkrst_seq
  import clkrst_seq_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int NRST     = CLKRST_NRST,
  parameter int RST_DLY  [NRST]  = CLKRST_RST_DLY,
  parameter int NSTRB    = CLKRST_NSTRB,
  parameter int STRB_DIV [NSTRB] = CLKRST_STRB_DIV,
  parameter int HOLD_CYC = 64,
  parameter int DLY_W    = CLKRST_DLY_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             resync_req,
  output logic [NRST-1:0]  rst_out,
  output logic             seq_done,
  output logic [NSTRB-1:0] strobe
);

  localparam int IDX_W = (NRST > 1) ? $clog2(NRST) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NRST - 1);
  localparam logic [DLY_W-1:0] HOLD_LD  = DLY_W'(HOLD_CYC);
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

  // ---------------------------------------------------------------- checks
  if (CLK_HZ < 1) begin : g_bad_clk
    $error("clkrst_seq: CLK_HZ must be positive");
  end
  if (NRST < 1 || NRST > 8) begin : g_bad_nrst
    $error("clkrst_seq: NRST out of range 1..8");
  end
  if (NSTRB < 1 || NSTRB > 8) begin : g_bad_nstrb
    $error("clkrst_seq: NSTRB out of range 1..8");
  end
  if (!dly_ok(HOLD_CYC, DLY_W)) begin : g_bad_hold
    $error("clkrst_seq: HOLD_CYC zero or too wide for DLY_W");
  end
  for (genvar gi = 0; gi < NRST; gi++) begin : g_chk_rst
    if (!dly_ok(RST_DLY[gi], DLY_W)) begin : g_bad
      $error("clkrst_seq: RST_DLY entry zero or too wide for DLY_W");
    end
  end
  for (genvar gk = 0; gk < NSTRB; gk++) begin : g_chk_strb
    if (!dly_ok(STRB_DIV[gk], DLY_W)) begin : g_bad
      $error("clkrst_seq: STRB_DIV entry zero or too wide for DLY_W");
    end
  end

  // ---------------------------------------------------------------- state
  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [NRST-1:0]  rst_q, rst_d;
  logic             done_q, done_d;
  logic             req_q;

  logic [DLY_W-1:0] dly0, dly_nxt;
  logic [IDX_W-1:0] idx_inc;
  logic             expire;

  assign dly0    = DLY_W'(RST_DLY[0]);
  assign idx_inc = idx_q + IDX_W'(1);
  assign expire  = (cnt_q == DLY_ONE);

  // Delay for the stage after the current one; don't-care on the last stage.
  always_comb begin
    dly_nxt = dly0;
    for (int i = 0; i < NRST; i++) begin
      if (idx_inc == IDX_W'(i)) dly_nxt = DLY_W'(RST_DLY[i]);
    end
  end

  // resync_req is registered before the FSM sees it, so the assert-all
  // takes effect one edge after the request is sampled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEQ;
      idx_q   <= '0;
      cnt_q   <= dly0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      req_q   <= resync_req;
    end
  end

  // Next state, stage index and the shared delay counter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      HOLD: begin
        if (req_q) begin
          cnt_d = HOLD_LD;            // further requests extend the hold
        end else if (expire) begin
          state_d = SEQ;
          idx_d   = '0;
          cnt_d   = dly0;
        end else begin
          cnt_d = cnt_q - DLY_ONE;
        end
      end
      SEQ: begin
        if (req_q) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else if (expire) begin
          if (idx_q == LAST_IDX) begin
            state_d = RUN;
          end else begin
            idx_d = idx_inc;
            cnt_d = dly_nxt;
          end
        end else begin
          cnt_d = cnt_q - DLY_ONE;
        end
      end
      RUN: begin
        if (req_q) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = HOLD_LD;
      end
    endcase
  end

  // Registered outputs. Stages clear one at a time in index order, which
  // keeps the release monotonic without any extra masking.
  always_comb begin
    rst_d  = rst_q;
    done_d = done_q;
    case (state_q)
      HOLD: begin
        rst_d  = '1;
        done_d = 1'b0;
      end
      SEQ: begin
        if (req_q) begin
          rst_d  = '1;
          done_d = 1'b0;
        end else if (expire) begin
          rst_d[idx_q] = 1'b0;
          if (idx_q == LAST_IDX) done_d = 1'b1;
        end
      end
      RUN: begin
        if (req_q) begin
          rst_d  = '1;
          done_d = 1'b0;
        end
      end
      default: begin
        rst_d  = '1;
        done_d = 1'b0;
      end
    endcase
  end

  assign rst_out  = rst_q;
  assign seq_done = done_q;

  // ---------------------------------------------------------------- strobes
  for (genvar gk = 0; gk < NSTRB; gk++) begin : g_strb
    strobe_div #(
      .DIV   (STRB_DIV[gk]),
      .DLY_W (DLY_W)
    ) u_strobe_div (
      .clk     (clk),
      .reset_n (reset_n),
      .strobe  (strobe[gk])
    );
  end

endmodule
